// File: rtl/first_nios2_system_sysid_arb_pkg.sv
// Shared constants for the two-master sysid arbiter: FSM state encoding,
// master count and the default readdata width.
package first_nios2_system_sysid_arb_pkg;

  localparam int unsigned NUM_MASTERS    = 2;
  localparam int unsigned DATA_W_DEFAULT = 32;

  // FSM state encoding
  localparam int unsigned STATE_W   = 2;
  localparam logic [1:0]  ST_IDLE   = 2'd0;
  localparam logic [1:0]  ST_ACCESS = 2'd1;
  localparam logic [1:0]  ST_RESP   = 2'd2;

endpackage

// File: rtl/first_nios2_system_sysid_rr2.sv
// Two-way round-robin choice, purely combinational.
//   req   : read requests, bit i for master i
//   ptr   : index of the master granted last
//   grant : one-hot winner (all zero when nothing is requested)
module first_nios2_system_sysid_rr2
  import first_nios2_system_sysid_arb_pkg::*;
(
  input  logic [NUM_MASTERS-1:0] req,
  input  logic                   ptr,
  output logic [NUM_MASTERS-1:0] grant
);

  // On a tie the master that was not granted last wins.
  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

endmodule

// File: rtl/first_nios2_system_sysid_arbiter.sv
// Two-master arbiter in front of the sysid control slave.
// Each accepted read takes one ACCESS cycle (slave addressed, data captured)
// followed by one RESP cycle (readdatavalid pulse), giving one read per two
// cycles back to back and a three-cycle request-to-data latency from idle.
//   clock, reset                   : single clock, async active-high reset
//   m0_/m1_address, m0_/m1_read    : master commands
//   m0_/m1_waitrequest             : low only for the granted master in ACCESS
//   m0_/m1_readdata, _readdatavalid: registered responses
//   s_address / s_readdata         : sysid slave side (slave data is combinational)
//   err                            : sticky protocol-violation flags per master
module first_nios2_system_sysid_arbiter
  import first_nios2_system_sysid_arb_pkg::*;
#(
  parameter int unsigned DATA_W    = DATA_W_DEFAULT,
  parameter logic        RESET_PTR = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_address,
  input  logic              m0_read,
  output logic              m0_waitrequest,
  output logic [DATA_W-1:0] m0_readdata,
  output logic              m0_readdatavalid,
  input  logic              m1_address,
  input  logic              m1_read,
  output logic              m1_waitrequest,
  output logic [DATA_W-1:0] m1_readdata,
  output logic              m1_readdatavalid,
  output logic              s_address,
  input  logic [DATA_W-1:0] s_readdata,
  output logic [1:0]        err
);

  logic [STATE_W-1:0]     state, state_nxt;
  logic                   grant, grant_nxt;   // index of the master being served
  logic                   ptr, ptr_nxt;       // index of the last completed grant
  logic [NUM_MASTERS-1:0] req, rr_grant;
  logic [NUM_MASTERS-1:0] wait_q, wait_nxt;
  logic [NUM_MASTERS-1:0] rdv_q, rdv_nxt;
  logic [NUM_MASTERS-1:0] err_q, err_nxt;
  logic [DATA_W-1:0]      rd0_q, rd0_nxt, rd1_q, rd1_nxt;
  logic                   granted_read;

  assign req = {m1_read, m0_read};

  first_nios2_system_sysid_rr2 u_rr2 (
    .req   (req),
    .ptr   (ptr),
    .grant (rr_grant)
  );

  assign granted_read = grant ? m1_read : m0_read;

  // Slave address follows the granted master live, so a late address change
  // before acceptance is honoured.
  assign s_address = (state == ST_ACCESS) ? (grant ? m1_address : m0_address) : 1'b0;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      grant <= 1'b0;
      ptr   <= RESET_PTR;
      wait_q <= '1;
      rdv_q  <= '0;
      err_q  <= '0;
      rd0_q  <= '0;
      rd1_q  <= '0;
    end else begin
      state  <= state_nxt;
      grant  <= grant_nxt;
      ptr    <= ptr_nxt;
      wait_q <= wait_nxt;
      rdv_q  <= rdv_nxt;
      err_q  <= err_nxt;
      rd0_q  <= rd0_nxt;
      rd1_q  <= rd1_nxt;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    grant_nxt = grant;
    ptr_nxt   = ptr;
    rdv_nxt   = '0;
    err_nxt   = err_q;
    rd0_nxt   = rd0_q;
    rd1_nxt   = rd1_q;
    wait_nxt  = '1;

    case (state)
      ST_IDLE: begin
        if (|req) begin
          state_nxt = ST_ACCESS;
          grant_nxt = (rr_grant == 2'b10);
        end
      end
      ST_ACCESS: begin
        if (granted_read) begin
          if (grant) rd1_nxt = s_readdata;
          else       rd0_nxt = s_readdata;
          rdv_nxt[grant] = 1'b1;
          ptr_nxt        = grant;
          state_nxt      = ST_RESP;
        end else begin
          // Master withdrew its read while being served.
          err_nxt[grant] = 1'b1;
          state_nxt      = ST_IDLE;
        end
      end
      ST_RESP: begin
        if (|req) begin
          state_nxt = ST_ACCESS;
          grant_nxt = (rr_grant == 2'b10);
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // Waitrequest is registered: drop it for the master entering ACCESS.
    if (state_nxt == ST_ACCESS) wait_nxt[grant_nxt] = 1'b0;
  end

  assign m0_waitrequest   = wait_q[0];
  assign m1_waitrequest   = wait_q[1];
  assign m0_readdatavalid = rdv_q[0];
  assign m1_readdatavalid = rdv_q[1];
  assign m0_readdata      = rd0_q;
  assign m1_readdata      = rd1_q;
  assign err              = err_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_arbiter.sv
// Self-checking bench for the sysid arbiter. The reference model tracks only
// "which master is being served this cycle" and "which master gets its
// response this cycle"; a cycle with no one served is a free arbitration slot.
module tb_first_nios2_system_sysid_arbiter;

  localparam int unsigned DW      = 32;
  localparam logic [31:0] SYSID_TS = 32'h514850F9;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    rd, ad;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic          s_address;
  logic [DW-1:0] s_readdata;
  logic [1:0]    err;

  always #5 clock = ~clock;

  // Sysid slave: timestamp word at address 1, ID word 0 at address 0.
  assign s_readdata = s_address ? SYSID_TS : 32'h0;

  first_nios2_system_sysid_arbiter #(.DATA_W(DW), .RESET_PTR(1'b1)) dut (
    .clock            (clock),
    .reset            (reset),
    .m0_address       (ad[0]),
    .m0_read          (rd[0]),
    .m0_waitrequest   (m0_waitrequest),
    .m0_readdata      (m0_readdata),
    .m0_readdatavalid (m0_readdatavalid),
    .m1_address       (ad[1]),
    .m1_read          (rd[1]),
    .m1_waitrequest   (m1_waitrequest),
    .m1_readdata      (m1_readdata),
    .m1_readdatavalid (m1_readdatavalid),
    .s_address        (s_address),
    .s_readdata       (s_readdata),
    .err              (err)
  );

  // Reference model state
  int          srv, resp;      // master served / answered this cycle, -1 = none
  logic        last;           // master served most recently
  logic [31:0] md0, md1;
  logic [1:0]  merr;

  int passed = 0, total = 0;
  int cyc = 0, n0 = 0, n1 = 0, t0 = 0, t1 = 0;
  logic [1:0] pend;

  function automatic logic [31:0] slave(logic a);
    return a ? SYSID_TS : 32'h0;
  endfunction

  function automatic int pick(logic [1:0] r, logic l);
    if (r == 2'b11) return l ? 0 : 1;
    return r[1] ? 1 : 0;
  endfunction

  task automatic model_reset();
    srv = -1; resp = -1; last = 1'b1; md0 = '0; md1 = '0; merr = '0;
  endtask

  // Advance model by one clock edge using the inputs held across it.
  task automatic advance();
    int ns, nr;
    logic r, a;
    ns = -1; nr = -1;
    if (srv >= 0) begin
      r = (srv == 1) ? rd[1] : rd[0];
      a = (srv == 1) ? ad[1] : ad[0];
      if (r) begin
        nr = srv;
        if (srv == 1) md1 = slave(a); else md0 = slave(a);
        last = (srv == 1);
      end else begin
        if (srv == 1) merr[1] = 1'b1; else merr[0] = 1'b1;
      end
    end else if (rd != 2'b00) begin
      ns = pick(rd, last);
    end
    srv = ns; resp = nr;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
  endtask

  task automatic check_all(string tag);
    logic [1:0] ewr, erdv;
    logic es;
    ewr = 2'b11; erdv = 2'b00; es = 1'b0;
    if (srv == 0)      begin ewr = 2'b10; es = ad[0]; end
    else if (srv == 1) begin ewr = 2'b01; es = ad[1]; end
    if (resp == 0)      erdv = 2'b01;
    else if (resp == 1) erdv = 2'b10;
    chk({tag, "_wait"}, 32'({m1_waitrequest, m0_waitrequest}), 32'(ewr));
    chk({tag, "_rdv"},  32'({m1_readdatavalid, m0_readdatavalid}), 32'(erdv));
    chk({tag, "_rd0"},  m0_readdata, md0);
    chk({tag, "_rd1"},  m1_readdata, md1);
    chk({tag, "_saddr"}, 32'(s_address), 32'(es));
    chk({tag, "_err"},  32'(err), 32'(merr));
  endtask

  // One clock cycle: inputs already set at the falling edge.
  task automatic step(string tag);
    #1;
    check_all(tag);
    if (m0_readdatavalid) begin n0++; t0 = cyc; end
    if (m1_readdatavalid) begin n1++; t1 = cyc; end
    @(posedge clock);
    advance();
    @(negedge clock);
    cyc++;
  endtask

  task automatic apply_reset(string tag);
    reset = 1'b1;
    #1;
    model_reset();
    pend = '0;
    check_all(tag);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic random_phase(int n, string tag);
    int was;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 2; i++) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin pend[i] = 1'b1; ad[i] = 1'($urandom); end
        end else if (srv != i && $urandom_range(0, 3) == 0) begin
          ad[i] = 1'($urandom);
        end
        rd[i] = pend[i];
        if (srv == i && $urandom_range(0, 15) == 0) rd[i] = 1'b0;
      end
      was = srv;
      step(tag);
      if (was == 0) pend[0] = 1'b0;
      if (was == 1) pend[1] = 1'b0;
    end
  endtask

  initial begin
    rd = '0; ad = '0; reset = 1'b0; pend = '0;
    model_reset();
    #1 reset = 1'b1;
    #1 check_all("reset");
    rd = 2'b11;
    @(negedge clock);
    #1 check_all("reset_hold");
    rd = 2'b00;
    @(negedge clock);
    reset = 1'b0;

    // Lone m0 read of the timestamp word.
    ad = 2'b01; rd = 2'b01;
    step("s1_idle"); step("s1_access");
    rd = 2'b00;
    step("s1_resp"); step("s1_done");
    chk("s1_m0_data", m0_readdata, SYSID_TS);
    chk("s1_m1_data", m1_readdata, 32'h0);

    // Simultaneous first requests: m0 first, m1 straight after.
    apply_reset("s2_reset");
    ad = 2'b11; rd = 2'b11;
    step("s2_idle"); step("s2_acc0");
    rd = 2'b10;
    step("s2_resp0"); step("s2_acc1");
    rd = 2'b00;
    step("s2_resp1"); step("s2_done");
    chk("s2_rdv_gap", 32'(t1 - t0), 32'd2);

    // Eight back-to-back transactions from both masters.
    n0 = 0; n1 = 0;
    rd = 2'b11;
    for (int k = 0; k < 16; k++) begin
      ad = 2'($urandom);
      step("s3_cont");
    end
    rd = 2'b00;
    step("s3_last"); step("s3_done");
    chk("s3_m0_count", 32'(n0), 32'd4);
    chk("s3_m1_count", 32'(n1), 32'd4);

    // m1 withdraws its read while being served.
    n1 = 0;
    ad = 2'b10; rd = 2'b10;
    step("s4_idle");
    rd = 2'b00;
    step("s4_viol"); step("s4_after");
    chk("s4_err", 32'(err), 32'd2);
    chk("s4_no_m1_rdv", 32'(n1), 32'd0);
    ad = 2'b01; rd = 2'b01;
    step("s4_m0_idle"); step("s4_m0_acc");
    rd = 2'b00;
    step("s4_m0_resp"); step("s4_m0_done");
    chk("s4_m0_data", m0_readdata, SYSID_TS);

    // Randomised traffic including occasional withdrawals.
    random_phase(400, "rand1");
    rd = 2'b00; pend = '0;
    step("rand1_drain"); step("rand1_drain");

    // Reset during the response cycle.
    apply_reset("s6_pre");
    ad = 2'b01; rd = 2'b01;
    step("s6_idle"); step("s6_acc");
    rd = 2'b00;
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("s6_rst");
    @(negedge clock);
    reset = 1'b0;
    n0 = 0; n1 = 0;
    for (int k = 0; k < 4; k++) step("s6_post");
    chk("s6_no_rdv", 32'(n0 + n1), 32'd0);

    random_phase(150, "rand2");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/first_nios2_system_sysid_arbiter.md
FIRST_NIOS2_SYSTEM_SYSID_ARBITER -- requirements
Module: first_nios2_system_sysid_arbiter

Interface
REQ-001 Parameter: DATA_W, 32, readdata width of the sysid control slave and of both master ports.
REQ-002 Parameter: RESET_PTR, 1, value of the last-grant pointer after reset, so master 0 wins the first tie.
REQ-003 Port: clock  in  1  single clock for all state.
REQ-004 Port: reset  in  1  asynchronous, active-high reset.
REQ-005 Port: m0_address / m1_address  in  1  sysid word select (0 = ID word, 1 = timestamp word) per master.
REQ-006 Port: m0_read / m1_read  in  1  read request; held by the master while its waitrequest is high.
REQ-007 Port: m0_waitrequest / m1_waitrequest  out  1  high = command not accepted.
REQ-008 Port: m0_readdata / m1_readdata  out  DATA_W  registered response data.
REQ-009 Port: m0_readdatavalid / m1_readdatavalid  out  1  one-cycle pulse qualifying readdata.
REQ-010 Port: s_address  out  1  address driven to the sysid control slave.
REQ-011 Port: s_readdata  in  DATA_W  combinational readdata from the sysid control slave.
REQ-012 Port: err  out  2  sticky protocol-violation flags, bit i for master i.

Function
REQ-013 FSM states SHALL be IDLE, ACCESS and RESP.
REQ-014 IDLE: any read high -> ACCESS, latching grant; only one requester -> that master; both -> the master not equal to the last-grant pointer.
REQ-015 ACCESS: s_address SHALL equal the granted master's address; that master's waitrequest SHALL be low for exactly this cycle; s_readdata SHALL be captured into that master's readdata register; the last-grant pointer SHALL update to the grant -> RESP.
REQ-016 RESP: the granted master's readdatavalid SHALL be high for exactly one cycle; the other master's readdatavalid SHALL stay low.
REQ-017 RESP: any read high -> ACCESS with a fresh round-robin grant; else -> IDLE; sustained throughput SHALL be one read per 2 cycles, and request-to-readdatavalid latency from IDLE SHALL be 3 cycles.
REQ-018 waitrequest SHALL be high for every master in every cycle except the granted master in ACCESS.
REQ-019 A non-granted master's readdata register SHALL hold its last value.
REQ-020 s_address SHALL be 0 outside ACCESS.
REQ-021 Under continuous requests from both masters, grants SHALL alternate strictly, with no master waiting more than one transaction.
REQ-022 Protocol violation (granted master's read low in ACCESS): no capture, no readdatavalid, no pointer update, err[i] set, -> IDLE.
REQ-023 err bits SHALL clear only on reset.
REQ-024 A master changing its address while waitrequest is high SHALL be served with the address present in ACCESS.

Reset
REQ-025 Asserting reset SHALL immediately force state = IDLE, last-grant pointer = RESET_PTR, both waitrequest = 1, both readdatavalid = 0, both readdata = 0, s_address = 0, err = 0.
REQ-026 Reset asserted during ACCESS or RESP SHALL abandon the transaction with no readdatavalid after release.
REQ-027 The first arbitration SHALL occur in the first clock edge after reset deasserts.

Structure
REQ-028 Shared package first_nios2_system_sysid_arb_pkg SHALL hold the FSM state encoding, the master-count constant (2) and the DATA_W default.
REQ-029 The round-robin choice SHALL be one sub-module, first_nios2_system_sysid_rr2 (inputs: two requests and the pointer; output: one-hot grant), which is purely combinational.
REQ-030 All other logic SHALL reside in the top module.

Verification
REQ-031 Slave model returns 0x514850F9 for address 1 and 0x00000000 for address 0; m0 reads address 1 alone -> m0_waitrequest low in cycle 2, m0_readdatavalid in cycle 3 with 0x514850F9, m1 untouched.
REQ-032 m0 and m1 both assert read at the same edge after reset -> m0 is served first, m1 next (ACCESS entered directly from RESP), m1 readdatavalid 2 cycles after m0's.
REQ-033 Both masters request continuously for 8 transactions -> grant order m0,m1,m0,m1,..., 4 responses each, readdatavalid every 2 cycles.
REQ-034 m1 is granted and drops read in ACCESS -> err = 2'b10, no m1_readdatavalid, FSM back in IDLE, next m0 read served normally.
REQ-035 Reset is asserted in RESP -> all outputs take the REQ-025 values within the same cycle, and no readdatavalid appears after release.
